// File: rtl/nibble_serial_subtractor_16_pkg.sv
// Shared constants and state encoding for the nibble-serial 16-bit subtractor.
package nibble_serial_subtractor_16_pkg;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned SLICE  = 4;
    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_subtractor_16_borrow_slice_4.sv
// 4-bit borrow-ripple subtractor slice: d = x - y - bi, bo = borrow out.
module borrow_slice_4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       bi,
    output logic [3:0] d,
    output logic       bo
);

    logic chain;

    always_comb begin
        d     = '0;
        chain = bi;
        for (int unsigned i = 0; i < 4; i++) begin
            d[i]  = x[i] ^ y[i] ^ chain;
            chain = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & chain);
        end
        bo = chain;
    end

endmodule

// File: rtl/nibble_serial_subtractor_16.sv
// Multi-cycle subtractor: one 4-bit slice per clock, borrow registered between
// slices, valid/ready handshakes on both sides.
module nibble_serial_subtractor_16
    import nibble_serial_subtractor_16_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               borrow;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;

    logic [SLICE-1:0]   x_s;
    logic [SLICE-1:0]   y_s;
    logic [SLICE-1:0]   d_s;
    logic               bo_s;
    logic               last;

    // Single slice instance; the counter selects which nibble it sees.
    assign x_s  = a_q[cnt*SLICE +: SLICE];
    assign y_s  = b_q[cnt*SLICE +: SLICE];
    assign last = (cnt == CNT_W'(NSLICE - 1));

    borrow_slice_4 u_slice (
        .x  (x_s),
        .y  (y_s),
        .bi (borrow),
        .d  (d_s),
        .bo (bo_s)
    );

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            borrow <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= a;
                        b_q    <= b;
                        borrow <= bin;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    diff[cnt*SLICE +: SLICE] <= d_s;
                    borrow <= bo_s;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        // Overflow uses the freshly computed top slice MSB.
                        bout  <= bo_s;
                        ovf   <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                 (d_s[SLICE-1] != a_q[WIDTH-1]);
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_subtractor_16.sv
// Self-checking bench: directed vector table, corner sequences, random ops vs. arithmetic model.
module tb_nibble_serial_subtractor_16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    nibble_serial_subtractor_16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bo;
        logic        ov;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned and signed views.
    function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin,
                                  output logic [15:0] md, output logic mbo, output logic mov);
        int ur;
        int sr;
        ur  = int'(ma) - int'(mb) - int'(mbin);
        sr  = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        md  = ur[15:0];
        mbo = (ur < 0);
        mov = (sr > 32767) || (sr < -32768);
    endfunction

    // Accepts one operation and waits for out_valid; lat = edges after the accept edge.
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                            output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = ta;
        b = tb_;
        bin = tbin;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_op(input int hold_cycles);
        repeat (hold_cycles) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    vec_t vecs[6];

    initial begin
        int          lat;
        logic [15:0] md;
        logic        mbo;
        logic        mov;
        logic [15:0] hd;
        logic        hbo;
        logic        hov;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rbin;

        vecs[0] = '{16'hF0F0, 16'h0F0F, 1'b1, 16'hE1E0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[3] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[5] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        bin = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_diff", 32'(diff), 32'h0);
        chk("reset_bout", 32'(bout), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            chk($sformatf("vec%0d_diff", i), 32'(diff), 32'(vecs[i].d));
            chk($sformatf("vec%0d_bout", i), 32'(bout), 32'(vecs[i].bo));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'(vecs[i].ov));
            release_op(0);
        end

        // Backpressure in HOLD
        start_op(16'h8000, 16'h0001, 1'b0, lat);
        hd = diff;
        hbo = bout;
        hov = ovf;
        chk("bp_diff", 32'(hd), 32'h7FFF);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_diff_stable", 32'(diff), 32'(hd));
            chk("bp_bout_stable", 32'(bout), 32'(hbo));
            chk("bp_ovf_stable", 32'(ovf), 32'(hov));
        end
        release_op(0);

        // Ignored input during RUN
        @(negedge clk);
        in_valid = 1'b1;
        a = 16'hF0F0;
        b = 16'h0F0F;
        bin = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = 16'hFFFF;
        b = 16'h0000;
        bin = 1'b0;
        chk("ign_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("ign_out_valid", 32'(out_valid), 32'd1);
        chk("ign_diff", 32'(diff), 32'hE1E0);
        release_op(0);
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("ign_no_second_op", 32'(out_valid), 32'd0);
        end
        chk("ign_idle_ready", 32'(in_ready), 32'd1);

        // Reset after E2
        @(negedge clk);
        in_valid = 1'b1;
        a = 16'hF0F0;
        b = 16'h0F0F;
        bin = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_diff", 32'(diff), 32'h0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(16'h0005, 16'h0003, 1'b0, lat);
        chk("midrst_new_latency", 32'(lat), 32'd4);
        chk("midrst_new_diff", 32'(diff), 32'h0002);
        chk("midrst_new_bout", 32'(bout), 32'd0);
        release_op(0);

        // Random operations against the arithmetic model
        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rbin = 1'($urandom_range(0, 1));
            if (i % 10 == 0) rb = ra;
            model(ra, rb, rbin, md, mbo, mov);
            start_op(ra, rb, rbin, lat);
            chk("rnd_latency", 32'(lat), 32'd4);
            chk("rnd_diff", 32'(diff), 32'(md));
            chk("rnd_bout", 32'(bout), 32'(mbo));
            chk("rnd_ovf", 32'(ovf), 32'(mov));
            release_op(int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
